alu_writeback_seq: RTL and testbench

- Downstream stage of the 8-bit ALU: consumes the 16-bit ALU result Q and writes it into the 32 x 8-bit general register file through a single byte-wide write port.
- Byte ops need one write. Multiply and explicit wide ops need two sequential writes (low byte, then high byte), so the block is a small FSM with valid/ready backpressure toward the ALU/decode stage.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_writeback_seq_if.sv | 30 +++
 rtl/alu_writeback_seq.sv | 127 ++++++++++++
 tb/tb_alu_writeback_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, default widths and the writeback FSM state encoding.
package alu_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WR_LO = 2'd1,
        WB_WR_HI = 2'd2
    } wb_state_e;

endpackage

// File: rtl/alu_writeback_seq_if.sv
// Bundle between the ALU/decode stage, the writeback sequencer and the register-file write port.
interface alu_writeback_seq_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*DATA_W-1:0]   in_result;
    logic [2:0]            in_op;
    logic [ADDR_W-1:0]     in_rd;
    logic                  in_wide;
    logic                  rf_we;
    logic [ADDR_W-1:0]     rf_addr;
    logic [DATA_W-1:0]     rf_wdata;
    logic                  done;
    logic                  busy;
    logic [ADDR_W-1:0]     q_addr;
    logic                  q_hit;
    logic [DATA_W-1:0]     q_data;

    modport slave (
        input  in_valid, in_result, in_op, in_rd, in_wide, q_addr,
        output in_ready, rf_we, rf_addr, rf_wdata, done, busy, q_hit, q_data
    );

    modport master (
        output in_valid, in_result, in_op, in_rd, in_wide, q_addr,
        input  in_ready, rf_we, rf_addr, rf_wdata, done, busy, q_hit, q_data
    );
endinterface

// File: rtl/alu_writeback_seq.sv
// Writes 16-bit ALU results into the byte-wide register file, one or two writes per result.
// Optional pending-write forwarding is enabled by defining ALU_WB_FORWARD_EN.
module alu_writeback_seq
    import alu_pkg::*;
#(
    parameter int         ADDR_W = ADDR_W_DEF,
    parameter int         DATA_W = DATA_W_DEF,
    parameter logic [2:0] MUL_OP = OP_MUL
) (
    input  logic                clk,
    input  logic                reset_n,
    alu_writeback_seq_if.slave  wb
);

    localparam logic [1:0] IDLE  = WB_IDLE;
    localparam logic [1:0] WR_LO = WB_WR_LO;
    localparam logic [1:0] WR_HI = WB_WR_HI;

    logic [1:0]          state_q, state_d;
    logic [2*DATA_W-1:0] result_q;
    logic [ADDR_W-1:0]   lo_addr_q, hi_addr_q;
    logic                wide_q;

    logic                accept;
    logic                wide_in;
    logic [ADDR_W-1:0]   lo_addr_in, hi_addr_in;

    // Multiply always lands in R1:R0; other wide ops pair an even register with its odd neighbour.
    always_comb begin
        wide_in    = wb.in_wide || (wb.in_op == MUL_OP);
        lo_addr_in = wb.in_rd;
        hi_addr_in = wb.in_rd;
        if (wb.in_op == MUL_OP) begin
            lo_addr_in = '0;
            hi_addr_in = ADDR_W'(1);
        end else if (wb.in_wide) begin
            lo_addr_in = {wb.in_rd[ADDR_W-1:1], 1'b0};
            hi_addr_in = {wb.in_rd[ADDR_W-1:1], 1'b1};
        end
    end

    // Ready whenever the current cycle is the last write of a transaction (or nothing is held).
    assign wb.in_ready = (state_q == IDLE) || (state_q == WR_HI) ||
                         ((state_q == WR_LO) && !wide_q);
    assign accept      = wb.in_valid && wb.in_ready;
    assign wb.busy     = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = WR_LO;
            WR_LO:   if (wide_q) state_d = WR_HI;
                     else        state_d = accept ? WR_LO : IDLE;
            WR_HI:   state_d = accept ? WR_LO : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the holding register is cleared on reset so the idle outputs and forwarding start from known zeros.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q  <= '0;
            lo_addr_q <= '0;
            hi_addr_q <= '0;
            wide_q    <= 1'b0;
        end else if (accept) begin
            result_q  <= wb.in_result;
            lo_addr_q <= lo_addr_in;
            hi_addr_q <= hi_addr_in;
            wide_q    <= wide_in;
        end
    end

    // Write port decoded purely from registered state and holding regs.
    always_comb begin
        wb.rf_we    = 1'b0;
        wb.rf_addr  = '0;
        wb.rf_wdata = '0;
        wb.done     = 1'b0;
        case (state_q)
            WR_LO: begin
                wb.rf_we    = 1'b1;
                wb.rf_addr  = lo_addr_q;
                wb.rf_wdata = result_q[DATA_W-1:0];
                wb.done     = !wide_q;
            end
            WR_HI: begin
                wb.rf_we    = 1'b1;
                wb.rf_addr  = hi_addr_q;
                wb.rf_wdata = result_q[2*DATA_W-1:DATA_W];
                wb.done     = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef ALU_WB_FORWARD_EN
    // Low byte is pending only in WR_LO; the high byte stays pending through WR_HI.
    always_comb begin
        wb.q_hit  = 1'b0;
        wb.q_data = '0;
        if ((state_q == WR_LO) && (wb.q_addr == lo_addr_q)) begin
            wb.q_hit  = 1'b1;
            wb.q_data = result_q[DATA_W-1:0];
        end else if (wide_q && ((state_q == WR_LO) || (state_q == WR_HI)) &&
                     (wb.q_addr == hi_addr_q)) begin
            wb.q_hit  = 1'b1;
            wb.q_data = result_q[2*DATA_W-1:DATA_W];
        end
    end
`else
    logic unused_q_addr;
    assign unused_q_addr = ^wb.q_addr;
    assign wb.q_hit      = 1'b0;
    assign wb.q_data     = '0;
`endif

endmodule

// File: tb/tb_alu_writeback_seq.sv
// Directed bench for alu_writeback_seq: expected register-file writes are queued on accept
// and compared as the DUT issues them.
module tb_alu_writeback_seq;
    import alu_pkg::*;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
        logic       done;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    wr_t  exp_q[$];

    alu_writeback_seq_if #(.ADDR_W(5), .DATA_W(8)) wb ();

    alu_writeback_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wb      (wb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference expectation for one accepted result.
    task automatic push_expected(input logic [2:0] op, input logic [4:0] rd,
                                 input logic wide, input logic [15:0] res);
        wr_t  lo, hi;
        logic weff;
        weff    = wide || (op == OP_MUL);
        lo.data = res[7:0];
        hi.data = res[15:8];
        lo.done = !weff;
        hi.done = 1'b1;
        if (op == OP_MUL) begin
            lo.addr = 5'd0;
            hi.addr = 5'd1;
        end else if (wide) begin
            lo.addr = {rd[4:1], 1'b0};
            hi.addr = {rd[4:1], 1'b1};
        end else begin
            lo.addr = rd;
            hi.addr = rd;
        end
        exp_q.push_back(lo);
        if (weff) exp_q.push_back(hi);
    endtask

    // One clock: edge, then at the falling edge compare this cycle's write against the queue.
    task automatic tick();
        wr_t e;
        logic exp_we;
        @(posedge clk);
        @(negedge clk);
        exp_we = (exp_q.size() > 0);
        check("rf_we", 16'(wb.rf_we), 16'(exp_we));
        check("busy", 16'(wb.busy), 16'(exp_we));
        if (exp_we) begin
            e = exp_q.pop_front();
            check("rf_addr", 16'(wb.rf_addr), 16'(e.addr));
            check("rf_wdata", 16'(wb.rf_wdata), 16'(e.data));
            check("done", 16'(wb.done), 16'(e.done));
        end else begin
            check("done_idle", 16'(wb.done), 16'h0);
        end
    endtask

    // Drive one cycle of upstream inputs; the bench predicts ready from its own pending writes.
    task automatic offer(input logic valid, input logic [2:0] op, input logic [4:0] rd,
                         input logic wide, input logic [15:0] res);
        logic exp_ready;
        wb.in_valid  = valid;
        wb.in_op     = op;
        wb.in_rd     = rd;
        wb.in_wide   = wide;
        wb.in_result = res;
        exp_ready    = (exp_q.size() == 0);
        #1;
        check("in_ready", 16'(wb.in_ready), 16'(exp_ready));
        if (valid && exp_ready) push_expected(op, rd, wide, res);
        tick();
    endtask

    task automatic idle();
        offer(1'b0, OP_ADD, 5'd0, 1'b0, 16'h0000);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rf_we"}, 16'(wb.rf_we), 16'h0);
        check({tag, "_rf_addr"}, 16'(wb.rf_addr), 16'h0);
        check({tag, "_rf_wdata"}, 16'(wb.rf_wdata), 16'h0);
        check({tag, "_done"}, 16'(wb.done), 16'h0);
        check({tag, "_busy"}, 16'(wb.busy), 16'h0);
        check({tag, "_q_hit"}, 16'(wb.q_hit), 16'h0);
        check({tag, "_q_data"}, 16'(wb.q_data), 16'h0);
    endtask

    initial begin
        reset_n      = 1'b0;
        wb.in_valid  = 1'b0;
        wb.in_op     = OP_ADD;
        wb.in_rd     = '0;
        wb.in_wide   = 1'b0;
        wb.in_result = '0;
        wb.q_addr    = '0;

        // Reset state
        #3;
        check_all_zero("reset");
        check("reset_ready", 16'(wb.in_ready), 16'h1);
        @(negedge clk);
        reset_n = 1'b1;

        // Single byte op, then a bubble
        offer(1'b1, OP_ADD, 5'd5, 1'b0, 16'h00A7);
        idle();

        // Multiply ignores rd and writes R0 then R1
        offer(1'b1, OP_MUL, 5'd9, 1'b0, 16'h1234);
        idle();
        idle();

        // Back-to-back byte ops, no bubbles
        offer(1'b1, OP_XOR, 5'd2, 1'b0, 16'hFF11);
        offer(1'b1, OP_OR,  5'd3, 1'b0, 16'h0022);
        offer(1'b1, OP_SUB, 5'd4, 1'b0, 16'h0033);
        idle();

        // Wide op with odd rd; a second request is stalled for one cycle then accepted
        offer(1'b1, OP_ADD, 5'd7, 1'b1, 16'hBEEF);
        offer(1'b1, OP_AND, 5'd10, 1'b0, 16'h0055);
        offer(1'b1, OP_AND, 5'd10, 1'b0, 16'h0055);
        idle();

        // Top of the register file, wide followed directly by another wide
        offer(1'b1, OP_ADD, 5'd31, 1'b1, 16'hC3A5);
        offer(1'b1, OP_SUB, 5'd12, 1'b1, 16'h7E81);
        offer(1'b1, OP_SUB, 5'd12, 1'b1, 16'h7E81);
        idle();
        idle();

        // Multiply interrupted by reset during its low write
        offer(1'b1, OP_MUL, 5'd20, 1'b0, 16'h1234);
        wb.in_valid = 1'b0;
        wb.q_addr   = 5'd1;
        #1;
`ifdef ALU_WB_FORWARD_EN
        check("fwd_hi_hit", 16'(wb.q_hit), 16'h1);
        check("fwd_hi_data", 16'(wb.q_data), 16'h12);
        wb.q_addr = 5'd0;
        #1;
        check("fwd_lo_hit", 16'(wb.q_hit), 16'h1);
        check("fwd_lo_data", 16'(wb.q_data), 16'h34);
        wb.q_addr = 5'd2;
        #1;
        check("fwd_miss_hit", 16'(wb.q_hit), 16'h0);
`else
        check("fwd_off_hit", 16'(wb.q_hit), 16'h0);
        check("fwd_off_data", 16'(wb.q_data), 16'h0);
`endif
        reset_n = 1'b0;
        #1;
        check_all_zero("abort");
        check("abort_ready", 16'(wb.in_ready), 16'h1);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_all_zero("abort_hold");
        reset_n = 1'b1;
        idle();
        idle();

        // Recovery after the abort
        offer(1'b1, OP_ADD, 5'd17, 1'b0, 16'h005A);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
